// File: rtl/sdram_arbiter.sv
// Two-client round-robin front end for sdram_controller; one transaction outstanding at a time.
// Latency: accept at E0 -> sdram_request_o after E0+1 (arbiter idle); controller done at D -> cN_done_o/cN_data_o/cN_ready_o after D.
// Backpressure: each client owns a one-entry slot (cN_ready_o low while full); issue holds until sdram_ready_i.
//
// Ports:
//   clock_i, resetn_i            : clock, async active-low reset
//   cN_request_i / cN_ready_o    : client request handshake (slot N empty when ready)
//   cN_command_i/length_i/address_i/data_i : client request fields (command 0=read, 1=write)
//   cN_data_o, cN_done_o         : last read data returned to client N, one-cycle completion pulse
//   sdram_request_o/command_o/length_o/address_o/data_o : request towards the controller
//   sdram_ready_i, sdram_data_i, sdram_done_i           : controller ready, read data, completion
module sdram_arbiter #(
  parameter int BW_BURST_LENGTH = 4,
  parameter int BW_ADDR         = 25,
  parameter int BW_DATA_BLOCK   = 512
) (
  input  logic                       clock_i,
  input  logic                       resetn_i,
  // client 0
  input  logic                       c0_request_i,
  input  logic                       c0_command_i,
  input  logic [BW_BURST_LENGTH-1:0] c0_length_i,
  input  logic [BW_ADDR-1:0]         c0_address_i,
  input  logic [BW_DATA_BLOCK-1:0]   c0_data_i,
  output logic                       c0_ready_o,
  output logic [BW_DATA_BLOCK-1:0]   c0_data_o,
  output logic                       c0_done_o,
  // client 1
  input  logic                       c1_request_i,
  input  logic                       c1_command_i,
  input  logic [BW_BURST_LENGTH-1:0] c1_length_i,
  input  logic [BW_ADDR-1:0]         c1_address_i,
  input  logic [BW_DATA_BLOCK-1:0]   c1_data_i,
  output logic                       c1_ready_o,
  output logic [BW_DATA_BLOCK-1:0]   c1_data_o,
  output logic                       c1_done_o,
  // controller side
  output logic                       sdram_request_o,
  output logic                       sdram_command_o,
  output logic [BW_BURST_LENGTH-1:0] sdram_length_o,
  output logic [BW_ADDR-1:0]         sdram_address_o,
  output logic [BW_DATA_BLOCK-1:0]   sdram_data_o,
  input  logic                       sdram_ready_i,
  input  logic [BW_DATA_BLOCK-1:0]   sdram_data_i,
  input  logic                       sdram_done_i
);

  typedef struct packed {
    logic                       cmd;
    logic [BW_BURST_LENGTH-1:0] len;
    logic [BW_ADDR-1:0]         addr;
    logic [BW_DATA_BLOCK-1:0]   data;
  } slot_t;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2
  } arb_state_t;

  arb_state_t                 r_state;
  slot_t                      r_slot0;
  slot_t                      r_slot1;
  logic                       r_full0;
  logic                       r_full1;
  logic                       r_c0_ready;
  logic                       r_c1_ready;
  logic                       r_owner;
  logic                       r_last_grant;
  logic                       r_c0_done;
  logic                       r_c1_done;
  logic [BW_DATA_BLOCK-1:0]   r_c0_data;
  logic [BW_DATA_BLOCK-1:0]   r_c1_data;
  logic                       r_sdram_req;
  logic                       r_sdram_cmd;
  logic [BW_BURST_LENGTH-1:0] r_sdram_len;
  logic [BW_ADDR-1:0]         r_sdram_addr;
  logic [BW_DATA_BLOCK-1:0]   r_sdram_data;

  slot_t w_in0;
  slot_t w_in1;
  slot_t w_gnt_slot;
  logic  w_acc0;
  logic  w_acc1;
  logic  w_cmpl;
  logic  w_free0;
  logic  w_free1;
  logic  w_full0_nxt;
  logic  w_full1_nxt;
  logic  w_any_full;
  logic  w_grant;

  assign w_in0 = {c0_command_i, c0_length_i, c0_address_i, c0_data_i};
  assign w_in1 = {c1_command_i, c1_length_i, c1_address_i, c1_data_i};

  // ready is only high while the slot is empty, so an accept always lands in an empty slot
  assign w_acc0 = c0_request_i & r_c0_ready;
  assign w_acc1 = c1_request_i & r_c1_ready;

  // done from the controller only counts while a transaction is outstanding
  assign w_cmpl  = (r_state == ARB_WAIT) & sdram_done_i;
  assign w_free0 = w_cmpl & ~r_owner;
  assign w_free1 = w_cmpl &  r_owner;

  assign w_full0_nxt = (r_full0 & ~w_free0) | w_acc0;
  assign w_full1_nxt = (r_full1 & ~w_free1) | w_acc1;

  // round robin: on a tie the client that was not served last wins
  assign w_any_full = r_full0 | r_full1;
  assign w_grant    = (r_full0 & r_full1) ? ~r_last_grant : r_full1;
  assign w_gnt_slot = w_grant ? r_slot1 : r_slot0;

  // client slots; ready is registered as "slot empty next cycle", which makes
  // ready rise together with the done pulse and one edge after reset release
  always_ff @(posedge clock_i or negedge resetn_i) begin
    if (!resetn_i) begin
      r_slot0    <= '0;
      r_slot1    <= '0;
      r_full0    <= 1'b0;
      r_full1    <= 1'b0;
      r_c0_ready <= 1'b0;
      r_c1_ready <= 1'b0;
    end else begin
      if (w_acc0) r_slot0 <= w_in0;
      if (w_acc1) r_slot1 <= w_in1;
      r_full0    <= w_full0_nxt;
      r_full1    <= w_full1_nxt;
      r_c0_ready <= ~w_full0_nxt;
      r_c1_ready <= ~w_full1_nxt;
    end
  end

  // arbitration / issue / completion state machine with registered outputs
  always_ff @(posedge clock_i or negedge resetn_i) begin
    if (!resetn_i) begin
      r_state      <= ARB_IDLE;
      r_owner      <= 1'b0;
      r_last_grant <= 1'b1;
      r_sdram_req  <= 1'b0;
      r_sdram_cmd  <= 1'b0;
      r_sdram_len  <= '0;
      r_sdram_addr <= '0;
      r_sdram_data <= '0;
      r_c0_done    <= 1'b0;
      r_c1_done    <= 1'b0;
      r_c0_data    <= '0;
      r_c1_data    <= '0;
    end else begin
      r_c0_done <= 1'b0;
      r_c1_done <= 1'b0;
      case (r_state)
        ARB_IDLE: begin
          if (w_any_full) begin
            r_owner      <= w_grant;
            r_sdram_cmd  <= w_gnt_slot.cmd;
            r_sdram_len  <= w_gnt_slot.len;
            r_sdram_addr <= w_gnt_slot.addr;
            r_sdram_data <= w_gnt_slot.data;
            r_sdram_req  <= 1'b1;
            r_state      <= ARB_ISSUE;
          end
        end
        ARB_ISSUE: begin
          // request is held high here, so ready alone completes the handshake
          if (sdram_ready_i) begin
            r_sdram_req <= 1'b0;
            r_state     <= ARB_WAIT;
          end
        end
        ARB_WAIT: begin
          if (sdram_done_i) begin
            // r_sdram_cmd still holds the owner's command
            if (r_owner) begin
              r_c1_done <= 1'b1;
              if (!r_sdram_cmd) r_c1_data <= sdram_data_i;
            end else begin
              r_c0_done <= 1'b1;
              if (!r_sdram_cmd) r_c0_data <= sdram_data_i;
            end
            r_last_grant <= r_owner;
            r_state      <= ARB_IDLE;
          end
        end
        default: r_state <= ARB_IDLE;
      endcase
    end
  end

  assign c0_ready_o      = r_c0_ready;
  assign c1_ready_o      = r_c1_ready;
  assign c0_done_o       = r_c0_done;
  assign c1_done_o       = r_c1_done;
  assign c0_data_o       = r_c0_data;
  assign c1_data_o       = r_c1_data;
  assign sdram_request_o = r_sdram_req;
  assign sdram_command_o = r_sdram_cmd;
  assign sdram_length_o  = r_sdram_len;
  assign sdram_address_o = r_sdram_addr;
  assign sdram_data_o    = r_sdram_data;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Bench for sdram_arbiter: transaction-level reference model plus a small controller model.
// Latency: outputs compared every falling edge against the model; directed checks pin key cycles.
// Backpressure: the controller model throttles sdram_ready_i under test control.
module tb_sdram_arbiter;
  localparam int BL = 4;
  localparam int BA = 25;
  localparam int BD = 512;
  typedef logic [BD-1:0] blk_t;

  logic          clock_i;
  logic          resetn_i;
  logic          c0_request_i, c1_request_i;
  logic          c0_command_i, c1_command_i;
  logic [BL-1:0] c0_length_i, c1_length_i;
  logic [BA-1:0] c0_address_i, c1_address_i;
  blk_t          c0_data_i, c1_data_i;
  logic          c0_ready_o, c1_ready_o;
  blk_t          c0_data_o, c1_data_o;
  logic          c0_done_o, c1_done_o;
  logic          sdram_request_o, sdram_command_o;
  logic [BL-1:0] sdram_length_o;
  logic [BA-1:0] sdram_address_o;
  blk_t          sdram_data_o;
  logic          sdram_ready_i, sdram_done_i;
  blk_t          sdram_data_i;

  sdram_arbiter #(.BW_BURST_LENGTH(BL), .BW_ADDR(BA), .BW_DATA_BLOCK(BD)) dut (
    .clock_i(clock_i), .resetn_i(resetn_i),
    .c0_request_i(c0_request_i), .c0_command_i(c0_command_i), .c0_length_i(c0_length_i),
    .c0_address_i(c0_address_i), .c0_data_i(c0_data_i), .c0_ready_o(c0_ready_o),
    .c0_data_o(c0_data_o), .c0_done_o(c0_done_o),
    .c1_request_i(c1_request_i), .c1_command_i(c1_command_i), .c1_length_i(c1_length_i),
    .c1_address_i(c1_address_i), .c1_data_i(c1_data_i), .c1_ready_o(c1_ready_o),
    .c1_data_o(c1_data_o), .c1_done_o(c1_done_o),
    .sdram_request_o(sdram_request_o), .sdram_command_o(sdram_command_o),
    .sdram_length_o(sdram_length_o), .sdram_address_o(sdram_address_o),
    .sdram_data_o(sdram_data_o), .sdram_ready_i(sdram_ready_i),
    .sdram_data_i(sdram_data_i), .sdram_done_i(sdram_done_i)
  );

  initial clock_i = 1'b0;
  always #5 clock_i = ~clock_i;

  int n_cmp = 0;
  int n_err = 0;
  int n_done0 = 0;
  int n_done1 = 0;

  task automatic chk(input string nm, input blk_t act, input blk_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic timeout(input string nm);
    n_cmp++;
    n_err++;
    $display("FAIL %s: timed out waiting (t=%0t)", nm, $time);
  endtask

  // ---------------- reference model (transaction view) ----------------
  bit [1:0]      m_full, m_rdy, m_done;
  logic          m_cmd [2];
  logic [BL-1:0] m_len [2];
  logic [BA-1:0] m_addr[2];
  blk_t          m_data[2];
  blk_t          m_dout[2];
  logic          m_req, m_f_cmd;
  logic [BL-1:0] m_f_len;
  logic [BA-1:0] m_f_addr;
  blk_t          m_f_data;
  int            m_owner, m_last;
  bit            m_busy, m_issued;

  task automatic model_reset();
    m_full = '0; m_rdy = '0; m_done = '0;
    for (int c = 0; c < 2; c++) begin
      m_cmd[c] = 1'b0; m_len[c] = '0; m_addr[c] = '0; m_data[c] = '0; m_dout[c] = '0;
    end
    m_req = 1'b0; m_f_cmd = 1'b0; m_f_len = '0; m_f_addr = '0; m_f_data = '0;
    m_owner = 0; m_last = 1; m_busy = 1'b0; m_issued = 1'b0;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clock_i or negedge resetn_i);
      if (!resetn_i) begin
        model_reset();
      end else begin
        bit [1:0] acc;
        int pick;
        acc[0] = c0_request_i & m_rdy[0];
        acc[1] = c1_request_i & m_rdy[1];
        m_done = '0;
        if (m_busy && m_issued) begin
          if (sdram_done_i) begin
            m_done[m_owner] = 1'b1;
            if (!m_f_cmd) m_dout[m_owner] = sdram_data_i;
            m_full[m_owner] = 1'b0;
            m_last = m_owner;
            m_busy = 1'b0;
            m_issued = 1'b0;
          end
        end else if (m_busy) begin
          if (sdram_ready_i) begin
            m_req = 1'b0;
            m_issued = 1'b1;
          end
        end else if (m_full != 2'b00) begin
          if (m_full == 2'b11) pick = (m_last == 1) ? 0 : 1;
          else pick = m_full[1] ? 1 : 0;
          m_owner = pick;
          m_f_cmd = m_cmd[pick]; m_f_len = m_len[pick];
          m_f_addr = m_addr[pick]; m_f_data = m_data[pick];
          m_req = 1'b1;
          m_busy = 1'b1;
        end
        if (acc[0]) begin
          m_full[0] = 1'b1; m_cmd[0] = c0_command_i; m_len[0] = c0_length_i;
          m_addr[0] = c0_address_i; m_data[0] = c0_data_i;
        end
        if (acc[1]) begin
          m_full[1] = 1'b1; m_cmd[1] = c1_command_i; m_len[1] = c1_length_i;
          m_addr[1] = c1_address_i; m_data[1] = c1_data_i;
        end
        m_rdy = ~m_full;
      end
    end
  end

  // ---------------- every-cycle compare ----------------
  initial begin
    forever begin
      @(negedge clock_i);
      chk("c0_ready",  blk_t'(c0_ready_o), blk_t'(m_rdy[0]));
      chk("c1_ready",  blk_t'(c1_ready_o), blk_t'(m_rdy[1]));
      chk("c0_done",   blk_t'(c0_done_o),  blk_t'(m_done[0]));
      chk("c1_done",   blk_t'(c1_done_o),  blk_t'(m_done[1]));
      chk("c0_data",   c0_data_o, m_dout[0]);
      chk("c1_data",   c1_data_o, m_dout[1]);
      chk("sd_req",    blk_t'(sdram_request_o), blk_t'(m_req));
      chk("sd_cmd",    blk_t'(sdram_command_o), blk_t'(m_f_cmd));
      chk("sd_len",    blk_t'(sdram_length_o),  blk_t'(m_f_len));
      chk("sd_addr",   blk_t'(sdram_address_o), blk_t'(m_f_addr));
      chk("sd_data",   sdram_data_o, m_f_data);
      if (c0_done_o) n_done0++;
      if (c1_done_o) n_done1++;
    end
  end

  // ---------------- controller model ----------------
  int            ctl_cs = 0;
  int            ctl_cnt = 0;
  int            ctl_lat = 3;
  bit            ctl_allow = 1'b1;
  blk_t          ctl_rdata = '0;
  logic [BA-1:0] log_q[$];

  initial begin
    bit hs;
    sdram_ready_i = 1'b0; sdram_done_i = 1'b0; sdram_data_i = '0;
    forever begin
      @(negedge clock_i);
      hs = sdram_request_o & sdram_ready_i & resetn_i;
      if (hs) log_q.push_back(sdram_address_o);
      @(posedge clock_i);
      #1;
      if (!resetn_i) begin
        ctl_cs = 0; sdram_ready_i = 1'b0; sdram_done_i = 1'b0;
      end else begin
        case (ctl_cs)
          0: if (hs) begin sdram_ready_i = 1'b0; ctl_cnt = ctl_lat; ctl_cs = 1; end
             else sdram_ready_i = ctl_allow;
          1: if (ctl_cnt == 0) begin sdram_done_i = 1'b1; sdram_data_i = ctl_rdata; ctl_cs = 2; end
             else ctl_cnt--;
          2: begin sdram_done_i = 1'b0; ctl_cs = 3; end
          default: begin ctl_cs = 0; sdram_ready_i = ctl_allow; end
        endcase
      end
    end
  end

  // ---------------- stimulus helpers (called at posedge+1) ----------------
  task automatic drive_req(input bit en0, input bit en1);
    bit p0, p1, a0, a1;
    p0 = en0; p1 = en1;
    c0_request_i = en0; c1_request_i = en1;
    for (int t = 0; t < 200 && (p0 || p1); t++) begin
      @(negedge clock_i);
      a0 = p0 & c0_ready_o;
      a1 = p1 & c1_ready_o;
      @(posedge clock_i);
      #1;
      if (a0) begin c0_request_i = 1'b0; p0 = 1'b0; end
      if (a1) begin c1_request_i = 1'b0; p1 = 1'b0; end
    end
    if (p0 || p1) begin
      c0_request_i = 1'b0; c1_request_i = 1'b0;
      timeout("accept");
    end
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int t = 0; t < 1000 && !ok; t++) begin
      @(posedge clock_i);
      #1;
      ok = c0_ready_o && c1_ready_o && !sdram_request_o && (ctl_cs == 0);
    end
    if (!ok) timeout("idle");
  endtask

  task automatic set_c0(input logic cmd, input logic [BL-1:0] len, input logic [BA-1:0] a, input blk_t d);
    c0_command_i = cmd; c0_length_i = len; c0_address_i = a; c0_data_i = d;
  endtask

  task automatic set_c1(input logic cmd, input logic [BL-1:0] len, input logic [BA-1:0] a, input blk_t d);
    c1_command_i = cmd; c1_length_i = len; c1_address_i = a; c1_data_i = d;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int   base, d0, d1;
    bit   ok;
    blk_t snap, pat;
    resetn_i = 1'b0;
    c0_request_i = 1'b0; c1_request_i = 1'b0;
    set_c0(1'b0, '0, '0, '0);
    set_c1(1'b0, '0, '0, '0);
    repeat (3) @(posedge clock_i);
    #1;
    chk("rst_c0_ready", blk_t'(c0_ready_o), '0);
    chk("rst_sd_req", blk_t'(sdram_request_o), '0);
    resetn_i = 1'b1;
    @(negedge clock_i);
    chk("rel_ready_before_edge", blk_t'(c1_ready_o), '0);
    @(posedge clock_i);
    #1;
    chk("rel_c0_ready", blk_t'(c0_ready_o), blk_t'(1));
    chk("rel_c1_ready", blk_t'(c1_ready_o), blk_t'(1));

    // simultaneous first pair: c0 wins the tie after reset
    ctl_rdata = {16{32'h0BADF00D}};
    set_c0(1'b0, 4'd1, 25'h0000100, '0);
    set_c1(1'b0, 4'd2, 25'h0000200, '0);
    drive_req(1'b1, 1'b1);
    wait_idle();
    chk("pairA_first",  blk_t'(log_q[0]), blk_t'(25'h0000100));
    chk("pairA_second", blk_t'(log_q[1]), blk_t'(25'h0000200));

    // single read
    ctl_rdata = blk_t'(32'hDEADBEEF);
    snap = c1_data_o;
    d0 = n_done0;
    set_c0(1'b0, 4'd0, 25'h0000400, '0);
    drive_req(1'b1, 1'b0);
    @(negedge clock_i);
    chk("rd_req_not_early", blk_t'(sdram_request_o), '0);
    @(posedge clock_i);
    #1;
    chk("rd_req_after_e1", blk_t'(sdram_request_o), blk_t'(1));
    chk("rd_addr", blk_t'(sdram_address_o), blk_t'(25'h0000400));
    wait_idle();
    chk("rd_done_once", blk_t'(n_done0 - d0), blk_t'(1));
    snap = snap;
    chk("rd_c0_data", blk_t'(c0_data_o[31:0]), blk_t'(32'hDEADBEEF));
    chk("rd_c1_untouched", c1_data_o, {16{32'h0BADF00D}});

    // second simultaneous pair: c0 was served last, so c1 goes first
    base = log_q.size();
    set_c0(1'b0, 4'd0, 25'h0000500, '0);
    set_c1(1'b0, 4'd0, 25'h0000600, '0);
    ctl_rdata = {16{32'h12345678}};
    drive_req(1'b1, 1'b1);
    wait_idle();
    chk("pairB_first",  blk_t'(log_q[base]),   blk_t'(25'h0000600));
    chk("pairB_second", blk_t'(log_q[base+1]), blk_t'(25'h0000500));

    // write pass-through with c1 data preset to 0xAA
    ctl_rdata = blk_t'(8'hAA);
    set_c1(1'b0, 4'd0, 25'h0000700, '0);
    drive_req(1'b0, 1'b1);
    wait_idle();
    chk("wr_preset", c1_data_o, blk_t'(8'hAA));
    ctl_rdata = blk_t'(8'h55);
    pat = {16{32'h11111111}};
    d1 = n_done1;
    set_c1(1'b1, 4'd3, 25'h0000800, pat);
    drive_req(1'b0, 1'b1);
    ok = 1'b0;
    for (int t = 0; t < 50 && !ok; t++) begin
      @(negedge clock_i);
      ok = sdram_request_o;
    end
    if (!ok) timeout("wr_issue");
    chk("wr_data", sdram_data_o, pat);
    chk("wr_cmd", blk_t'(sdram_command_o), blk_t'(1));
    chk("wr_len", blk_t'(sdram_length_o), blk_t'(3));
    wait_idle();
    chk("wr_done_once", blk_t'(n_done1 - d1), blk_t'(1));
    chk("wr_c1_data_kept", c1_data_o, blk_t'(8'hAA));

    // ready backpressure for 10 cycles
    ctl_allow = 1'b0;
    repeat (2) @(posedge clock_i);
    #1;
    ctl_rdata = blk_t'(32'hCAFE0001);
    set_c0(1'b0, 4'd5, 25'h0000900, '0);
    drive_req(1'b1, 1'b0);
    ok = 1'b0;
    for (int t = 0; t < 20 && !ok; t++) begin
      @(negedge clock_i);
      ok = sdram_request_o;
    end
    if (!ok) timeout("bp_issue");
    for (int t = 0; t < 10; t++) begin
      @(negedge clock_i);
      chk("bp_req_held", blk_t'(sdram_request_o), blk_t'(1));
      chk("bp_addr_held", blk_t'(sdram_address_o), blk_t'(25'h0000900));
      chk("bp_c0_ready_low", blk_t'(c0_ready_o), '0);
    end
    ctl_allow = 1'b1;
    ok = 1'b0;
    for (int t = 0; t < 100 && !ok; t++) begin
      @(negedge clock_i);
      if (c0_done_o) begin
        ok = 1'b1;
        chk("bp_ready_with_done", blk_t'(c0_ready_o), blk_t'(1));
      end else begin
        chk("bp_ready_low_until_done", blk_t'(c0_ready_o), '0);
      end
    end
    if (!ok) timeout("bp_done");
    wait_idle();

    // re-request in the done cycle while c1 is pending
    ctl_lat = 6;
    base = log_q.size();
    set_c0(1'b0, 4'd0, 25'h0000A00, '0);
    drive_req(1'b1, 1'b0);
    set_c1(1'b0, 4'd0, 25'h0000B00, '0);
    drive_req(1'b0, 1'b1);
    set_c0(1'b0, 4'd0, 25'h0000C00, '0);
    ok = 1'b0;
    for (int t = 0; t < 100 && !ok; t++) begin
      @(posedge clock_i);
      #1;
      ok = c0_done_o;
    end
    if (!ok) timeout("rr_done");
    c0_request_i = 1'b1;
    @(posedge clock_i);
    #1;
    c0_request_i = 1'b0;
    chk("rr_accepted", blk_t'(c0_ready_o), '0);
    wait_idle();
    chk("rr_order0", blk_t'(log_q[base]),   blk_t'(25'h0000A00));
    chk("rr_order1", blk_t'(log_q[base+1]), blk_t'(25'h0000B00));
    chk("rr_order2", blk_t'(log_q[base+2]), blk_t'(25'h0000C00));

    // reset while waiting on the controller
    ctl_lat = 20;
    set_c1(1'b0, 4'd0, 25'h0000D00, '0);
    drive_req(1'b0, 1'b1);
    ok = 1'b0;
    for (int t = 0; t < 50 && !ok; t++) begin
      @(posedge clock_i);
      #1;
      ok = (ctl_cs == 1);
    end
    if (!ok) timeout("mid_wait");
    d0 = n_done0; d1 = n_done1;
    #2;
    resetn_i = 1'b0;
    #1;
    chk("mid_c0_data", c0_data_o, '0);
    chk("mid_c1_data", c1_data_o, '0);
    chk("mid_c0_ready", blk_t'(c0_ready_o), '0);
    chk("mid_c1_ready", blk_t'(c1_ready_o), '0);
    chk("mid_sd_req", blk_t'(sdram_request_o), '0);
    chk("mid_sd_addr", blk_t'(sdram_address_o), '0);
    repeat (3) @(posedge clock_i);
    #1;
    resetn_i = 1'b1;
    @(negedge clock_i);
    chk("mid_rel_before_edge", blk_t'(c0_ready_o), '0);
    @(posedge clock_i);
    #1;
    chk("mid_rel_c0_ready", blk_t'(c0_ready_o), blk_t'(1));
    chk("mid_rel_c1_ready", blk_t'(c1_ready_o), blk_t'(1));
    chk("mid_no_done", blk_t'((n_done0 - d0) + (n_done1 - d1)), '0);

    // tie after reset goes to c0 again
    ctl_lat = 2;
    base = log_q.size();
    set_c0(1'b0, 4'd0, 25'h0000E00, '0);
    set_c1(1'b0, 4'd0, 25'h0000F00, '0);
    drive_req(1'b1, 1'b1);
    wait_idle();
    chk("post_rst_first",  blk_t'(log_q[base]),   blk_t'(25'h0000E00));
    chk("post_rst_second", blk_t'(log_q[base+1]), blk_t'(25'h0000F00));

    repeat (3) @(posedge clock_i);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
